// File: rtl/vx_operands_scalar_if.sv
// rtl/vx_operands_scalar_if.sv - issue, writeback and dispatch signal bundle for vx_operands_scalar
//   in_*  : scoreboard-side instruction handshake (valid/ready, warp index, thread mask, metadata, rs indices, used mask)
//   wb_*  : register writeback, no backpressure
//   out_* : dispatch-side handshake (valid/ready, warp index, thread mask, metadata, operand data)
//   master: driver of in_*/wb_* and out_ready; slave: the operand collector
interface vx_operands_scalar_if #(
  parameter int THREAD_CNT  = 4,
  parameter int XLEN        = 32,
  parameter int NR_BITS     = 6,
  parameter int ISSUE_WIS_W = 2,
  parameter int META_W      = 128
);
  logic                         in_valid;
  logic                         in_ready;
  logic [ISSUE_WIS_W-1:0]       in_wis;
  logic [THREAD_CNT-1:0]        in_tmask;
  logic [META_W-1:0]            in_meta;
  logic [NR_BITS-1:0]           in_rs1;
  logic [NR_BITS-1:0]           in_rs2;
  logic [NR_BITS-1:0]           in_rs3;
  logic [2:0]                   in_used_rs;

  logic                         wb_valid;
  logic [ISSUE_WIS_W-1:0]       wb_wis;
  logic [NR_BITS-1:0]           wb_rd;
  logic [THREAD_CNT-1:0]        wb_tmask;
  logic [THREAD_CNT*XLEN-1:0]   wb_data;

  logic                         out_valid;
  logic                         out_ready;
  logic [ISSUE_WIS_W-1:0]       out_wis;
  logic [THREAD_CNT-1:0]        out_tmask;
  logic [META_W-1:0]            out_meta;
  logic [THREAD_CNT*XLEN-1:0]   out_rs1_data;
  logic [THREAD_CNT*XLEN-1:0]   out_rs2_data;
  logic [THREAD_CNT*XLEN-1:0]   out_rs3_data;

  modport master (
    output in_valid, in_wis, in_tmask, in_meta, in_rs1, in_rs2, in_rs3, in_used_rs,
    input  in_ready,
    output wb_valid, wb_wis, wb_rd, wb_tmask, wb_data,
    input  out_valid, out_wis, out_tmask, out_meta, out_rs1_data, out_rs2_data, out_rs3_data,
    output out_ready
  );

  modport slave (
    input  in_valid, in_wis, in_tmask, in_meta, in_rs1, in_rs2, in_rs3, in_used_rs,
    output in_ready,
    input  wb_valid, wb_wis, wb_rd, wb_tmask, wb_data,
    output out_valid, out_wis, out_tmask, out_meta, out_rs1_data, out_rs2_data, out_rs3_data,
    input  out_ready
  );
endinterface

// File: rtl/vx_operands_scalar.sv
// rtl/vx_operands_scalar.sv - single-read-port operand collector with per-warp register file
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   bus         : vx_operands_scalar_if slave (in_*, wb_*, out_* groups)
//   perf_stalls : 44-bit count of cycles with out_valid && !out_ready
module vx_operands_scalar #(
  parameter int THREAD_CNT  = 4,
  parameter int XLEN        = 32,
  parameter int NR_BITS     = 6,
  parameter int ISSUE_WIS_W = 2,
  parameter int META_W      = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_operands_scalar_if.slave  bus,
  output logic [43:0]          perf_stalls
);
  localparam int DATA_W   = THREAD_CNT * XLEN;
  localparam int ADDR_W   = ISSUE_WIS_W + NR_BITS;
  localparam int RF_DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_OUT} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             pend_q, pend_d;
  logic [43:0]            stalls_q, stalls_d;
  logic [ISSUE_WIS_W-1:0] wis_q, wis_d;
  logic [THREAD_CNT-1:0]  tmask_q, tmask_d;
  logic [META_W-1:0]      meta_q, meta_d;
  logic [NR_BITS-1:0]     rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;
  logic [DATA_W-1:0]      data1_q, data1_d, data2_q, data2_d, data3_q, data3_d;

  logic [DATA_W-1:0]      rf_q [RF_DEPTH];

  logic                   in_fire;
  logic                   out_valid;
  logic [2:0]             src_used;
  logic [2:0]             sel;
  logic [ISSUE_WIS_W-1:0] src_wis;
  logic [NR_BITS-1:0]     rd_idx;
  logic                   fwd_hit;
  logic [DATA_W-1:0]      rd_raw;
  logic [DATA_W-1:0]      rd_data;

  assign bus.in_ready     = (state_q == S_IDLE) && !reset;
  assign in_fire          = bus.in_valid && bus.in_ready;
  assign out_valid        = (state_q == S_OUT);
  assign bus.out_valid    = out_valid;
  assign bus.out_wis      = wis_q;
  assign bus.out_tmask    = tmask_q;
  assign bus.out_meta     = meta_q;
  assign bus.out_rs1_data = data1_q;
  assign bus.out_rs2_data = data2_q;
  assign bus.out_rs3_data = data3_q;
  assign perf_stalls      = stalls_q;

  // The first operand is read straight from the incoming indices in the
  // handshake cycle, so an instruction needing N operands is ready after
  // max(N,1) cycles; READ then drains whatever remains in pend_q.
  always_comb begin
    src_used = '0;
    src_wis  = wis_q;
    rd_idx   = '0;
    if (in_fire) begin
      src_used = bus.in_used_rs;
      src_wis  = bus.in_wis;
    end else if (state_q == S_READ) begin
      src_used = pend_q;
    end
    // Isolate the lowest pending operand: rs1 before rs2 before rs3.
    sel = src_used & (~src_used + 3'd1);
    if (sel[0])      rd_idx = in_fire ? bus.in_rs1 : rs1_q;
    else if (sel[1]) rd_idx = in_fire ? bus.in_rs2 : rs2_q;
    else if (sel[2]) rd_idx = in_fire ? bus.in_rs3 : rs3_q;
  end

  // Combinational read with same-cycle writeback bypass on masked lanes.
  always_comb begin
    rd_raw  = rf_q[{src_wis, rd_idx}];
    fwd_hit = bus.wb_valid && (bus.wb_wis == src_wis) && (bus.wb_rd == rd_idx);
    rd_data = rd_raw;
    for (int i = 0; i < THREAD_CNT; i++) begin
      if (fwd_hit && bus.wb_tmask[i]) rd_data[i*XLEN +: XLEN] = bus.wb_data[i*XLEN +: XLEN];
    end
    if (rd_idx == '0) rd_data = '0;
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    wis_d    = wis_q;
    tmask_d  = tmask_q;
    meta_d   = meta_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rs3_d    = rs3_q;
    data1_d  = data1_q;
    data2_d  = data2_q;
    data3_d  = data3_q;
    stalls_d = stalls_q + {43'd0, (out_valid && !bus.out_ready)};

    case (state_q)
      S_IDLE: begin
        if (in_fire) begin
          wis_d   = bus.in_wis;
          tmask_d = bus.in_tmask;
          meta_d  = bus.in_meta;
          rs1_d   = bus.in_rs1;
          rs2_d   = bus.in_rs2;
          rs3_d   = bus.in_rs3;
          data1_d = '0;
          data2_d = '0;
          data3_d = '0;
          pend_d  = src_used & ~sel;
          state_d = (pend_d == 3'b000) ? S_OUT : S_READ;
        end
      end
      S_READ: begin
        pend_d  = src_used & ~sel;
        state_d = (pend_d == 3'b000) ? S_OUT : S_READ;
      end
      S_OUT: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // sel is zero unless an operand is being read this cycle.
    if (sel[0]) data1_d = rd_data;
    if (sel[1]) data2_d = rd_data;
    if (sel[2]) data3_d = rd_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pend_q   <= '0;
      stalls_q <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      stalls_q <= stalls_d;
    end
  end

  always_ff @(posedge clk) begin
    wis_q   <= wis_d;
    tmask_q <= tmask_d;
    meta_q  <= meta_d;
    rs1_q   <= rs1_d;
    rs2_q   <= rs2_d;
    rs3_q   <= rs3_d;
    data1_q <= data1_d;
    data2_q <= data2_d;
    data3_q <= data3_d;
  end

  // Register 0 is hardwired to zero, so writes to it are dropped.
  always_ff @(posedge clk) begin
    if (bus.wb_valid && (bus.wb_rd != '0)) begin
      for (int i = 0; i < THREAD_CNT; i++) begin
        if (bus.wb_tmask[i]) rf_q[{bus.wb_wis, bus.wb_rd}][i*XLEN +: XLEN] <= bus.wb_data[i*XLEN +: XLEN];
      end
    end
  end
endmodule

// File: tb/tb_vx_operands_scalar.sv
// tb/tb_vx_operands_scalar.sv - directed self-checking bench for vx_operands_scalar
module tb_vx_operands_scalar;
  logic        clk = 1'b0;
  logic        reset;
  logic [43:0] perf_stalls;
  int          checks = 0;
  int          failures = 0;

  vx_operands_scalar_if bus ();

  vx_operands_scalar dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .perf_stalls (perf_stalls)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] lanes(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic [1:0] wis, input logic [5:0] rd, input logic [3:0] tm, input logic [127:0] d);
    bus.wb_valid = 1'b1;
    bus.wb_wis   = wis;
    bus.wb_rd    = rd;
    bus.wb_tmask = tm;
    bus.wb_data  = d;
  endtask

  task automatic issue(input logic [1:0] wis, input logic [5:0] r1, r2, r3, input logic [2:0] used, input logic [127:0] meta);
    bus.in_valid   = 1'b1;
    bus.in_wis     = wis;
    bus.in_tmask   = 4'hF;
    bus.in_meta    = meta;
    bus.in_rs1     = r1;
    bus.in_rs2     = r2;
    bus.in_rs3     = r3;
    bus.in_used_rs = used;
  endtask

  localparam logic [127:0] M1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] M2 = 128'hDEAD_BEEF_0000_0001_CAFE_F00D_0000_0002;

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_wis = '0; bus.in_tmask = '0; bus.in_meta = '0;
    bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rs3 = '0; bus.in_used_rs = '0;
    bus.wb_valid = 1'b0; bus.wb_wis = '0; bus.wb_rd = '0; bus.wb_tmask = '0; bus.wb_data = '0;
    bus.out_ready = 1'b1;

    tick(); tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_perf", perf_stalls, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Populate w1.r5 = {1,2,3,4} and w1.r7 = {9,9,9,9}.
    wb(2'd1, 6'd5, 4'hF, lanes(1, 2, 3, 4));
    tick();
    wb(2'd1, 6'd7, 4'hF, lanes(9, 9, 9, 9));
    tick();
    bus.wb_valid = 1'b0;

    // Single operand: out_valid one cycle after the handshake.
    issue(2'd1, 6'd5, 6'd0, 6'd0, 3'b001, M1);
    tick();
    bus.in_valid = 1'b0;
    chk("one_out_valid", bus.out_valid, 1);
    chk("one_rs1", bus.out_rs1_data, lanes(1, 2, 3, 4));
    chk("one_rs2", bus.out_rs2_data, 0);
    chk("one_rs3", bus.out_rs3_data, 0);
    chk("one_meta", bus.out_meta, M1);
    chk("one_wis", bus.out_wis, 1);
    chk("one_tmask", bus.out_tmask, 4'hF);
    tick();
    chk("one_done_valid", bus.out_valid, 0);
    chk("one_done_ready", bus.in_ready, 1);

    // Three operands with rs2 = r0: out_valid exactly three cycles later.
    issue(2'd1, 6'd5, 6'd0, 6'd7, 3'b111, M2);
    tick();
    issue(2'd2, 6'd7, 6'd7, 6'd7, 3'b001, M1);
    chk("three_c1_valid", bus.out_valid, 0);
    chk("three_c1_ready", bus.in_ready, 0);
    tick();
    chk("three_c2_valid", bus.out_valid, 0);
    tick();
    bus.in_valid = 1'b0;
    chk("three_c3_valid", bus.out_valid, 1);
    chk("three_rs1", bus.out_rs1_data, lanes(1, 2, 3, 4));
    chk("three_rs2", bus.out_rs2_data, 0);
    chk("three_rs3", bus.out_rs3_data, lanes(9, 9, 9, 9));
    chk("three_meta", bus.out_meta, M2);
    tick();

    // Bypass: partial writeback to w1.r5 in the very cycle rs1=r5 is read.
    issue(2'd1, 6'd5, 6'd0, 6'd0, 3'b001, M1);
    wb(2'd1, 6'd5, 4'b0101, lanes(32'hA, 32'hA, 32'hA, 32'hA));
    tick();
    bus.in_valid = 1'b0;
    bus.wb_valid = 1'b0;
    chk("fwd_rs1", bus.out_rs1_data, lanes(32'hA, 2, 32'hA, 4));
    tick();
    issue(2'd1, 6'd5, 6'd0, 6'd0, 3'b001, M1);
    tick();
    bus.in_valid = 1'b0;
    chk("fwd_stored_rs1", bus.out_rs1_data, lanes(32'hA, 2, 32'hA, 4));
    tick();

    // No operands, then a 5-cycle dispatch stall.
    bus.out_ready = 1'b0;
    issue(2'd3, 6'd5, 6'd7, 6'd7, 3'b000, M2);
    tick();
    issue(2'd0, 6'd7, 6'd7, 6'd7, 3'b111, M1);
    chk("none_out_valid", bus.out_valid, 1);
    chk("none_rs1", bus.out_rs1_data, 0);
    chk("none_rs2", bus.out_rs2_data, 0);
    chk("none_rs3", bus.out_rs3_data, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("stall_out_valid", bus.out_valid, 1);
    chk("stall_meta", bus.out_meta, M2);
    chk("stall_wis", bus.out_wis, 3);
    chk("stall_rs3", bus.out_rs3_data, 0);
    chk("stall_perf", perf_stalls, 5);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("stall_done_valid", bus.out_valid, 0);
    chk("stall_perf_hold", perf_stalls, 5);

    // Reset while in READ discards the instruction and clears perf_stalls.
    issue(2'd1, 6'd5, 6'd7, 6'd7, 3'b111, M1);
    tick();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("rr_out_valid", bus.out_valid, 0);
    chk("rr_in_ready", bus.in_ready, 0);
    chk("rr_perf", perf_stalls, 0);
    reset = 1'b0;
    #1;
    chk("rr_in_ready_rel", bus.in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rr_no_output", bus.out_valid, 0);
    end

    // Writes to r0 are dropped and r0 always reads zero, even when bypassed.
    wb(2'd0, 6'd0, 4'hF, lanes(32'hF, 32'hF, 32'hF, 32'hF));
    tick();
    issue(2'd0, 6'd0, 6'd0, 6'd0, 3'b001, M1);
    tick();
    bus.in_valid = 1'b0;
    bus.wb_valid = 1'b0;
    chk("r0_valid", bus.out_valid, 1);
    chk("r0_rs1", bus.out_rs1_data, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
